// File: rtl/fp_norm_pkg.sv
// Shared definitions for the FP adder post-addition normaliser.
//   cls_e     : class of a raw sum, decided in stage 1
//   *_DEF     : default exponent / mantissa widths
//   EXP_MAX() : all-ones biased exponent (infinity / NaN encoding)
package fp_norm_pkg;

  typedef enum logic [1:0] {
    ZERO,
    CARRY,
    NORM
  } cls_e;

  localparam int EXP_W_DEF = 8;
  localparam int MAN_W_DEF = 25;

  function automatic int EXP_MAX(input int exp_w);
    return (1 << exp_w) - 1;
  endfunction

endpackage

// File: rtl/fp_lzc.sv
// Leading-zero counter, purely combinational.
//   in_bits : W-bit operand, MSB first
//   cnt     : number of leading zeros; all-zero input gives W
// Binary priority tree: the operand is padded on the LSB side with ones up
// to the next power of two, so the tree never sees an all-zero word and
// the all-zero operand naturally counts to exactly W.
module fp_lzc #(
  parameter int W = 24,
  localparam int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  in_bits,
  output logic [CW-1:0] cnt
);

  localparam int P = 1 << CW;

  logic [P-1:0] x;
  assign x = {in_bits, {(P - W){1'b1}}};

  always_comb begin
    logic [P-1:0]         vv;
    logic [P-1:0][CW-1:0] cc;
    vv = x;
    cc = '0;
    // Level k merges pairs in place: node n takes children 2n (low) and
    // 2n+1 (high). A zero high half adds 2^k and defers to the low half.
    for (int k = 0; k < CW; k++) begin
      for (int n = 0; n < (P >> (k + 1)); n++) begin
        if (vv[2*n+1]) cc[n] = cc[2*n+1];
        else           cc[n] = cc[2*n] | CW'(1 << k);
        vv[n] = vv[2*n+1] | vv[2*n];
      end
    end
    cnt = cc[0];
  end

endmodule

// File: rtl/fp_add_normaliser_pipe.sv
// Two-stage post-addition normaliser between the mantissa adder and the
// rounding/packing stage.
//   clk, reset           : clock, async active-high reset
//   in_valid/in_ready    : upstream handshake; in_sign/in_e/in_m/in_tag raw sum
//   out_valid/out_ready  : downstream handshake
//   out_sign/out_tag     : passed through
//   out_e/out_m          : normalised exponent / mantissa (carry bit always 0)
//   out_guard            : bit shifted out by a carry right-shift
//   out_zero/ovf/unf     : exact zero / overflow to infinity / denormal
// Stage 1 classifies the sum and counts leading zeros; stage 2 shifts and
// adjusts the exponent. Each stage stalls only when it is full and the
// stage after it cannot drain, so throughput is one op per cycle.
module fp_add_normaliser_pipe
  import fp_norm_pkg::*;
#(
  parameter int EXP_W = EXP_W_DEF,
  parameter int MAN_W = MAN_W_DEF,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [EXP_W-1:0] in_e,
  input  logic [MAN_W-1:0] in_m,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sign,
  output logic [EXP_W-1:0] out_e,
  output logic [MAN_W-1:0] out_m,
  output logic             out_guard,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_zero,
  output logic             out_ovf,
  output logic             out_unf
);

  localparam int LZW = $clog2(MAN_W);

  logic [2:1]       vld_pipe_q, vld_pipe_d;
  logic             s1_ready, s2_ready;
  logic [LZW-1:0]   lzc_w;

  logic             s1_sign_q, s1_sign_d;
  logic [EXP_W-1:0] s1_e_q, s1_e_d;
  logic [MAN_W-1:0] s1_m_q, s1_m_d;
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
  cls_e             s1_cls_q, s1_cls_d;
  logic [LZW-1:0]   s1_lzc_q, s1_lzc_d;

  logic             out_sign_q, out_sign_d;
  logic [EXP_W-1:0] out_e_q, out_e_d;
  logic [MAN_W-1:0] out_m_q, out_m_d;
  logic             out_guard_q, out_guard_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;
  logic             out_zero_q, out_zero_d;
  logic             out_ovf_q, out_ovf_d;
  logic             out_unf_q, out_unf_d;

  logic [EXP_W:0]   e_inc, lzc_x;

  fp_lzc #(.W(MAN_W - 1)) u_lzc (
    .in_bits (in_m[MAN_W-2:0]),
    .cnt     (lzc_w)
  );

  // Handshake and stage 1
  always_comb begin
    s2_ready      = !vld_pipe_q[2] || out_ready;
    s1_ready      = !vld_pipe_q[1] || s2_ready;
    vld_pipe_d[1] = s1_ready ? in_valid : vld_pipe_q[1];
    vld_pipe_d[2] = s2_ready ? vld_pipe_q[1] : vld_pipe_q[2];

    s1_sign_d = s1_sign_q;
    s1_e_d    = s1_e_q;
    s1_m_d    = s1_m_q;
    s1_tag_d  = s1_tag_q;
    s1_cls_d  = s1_cls_q;
    s1_lzc_d  = s1_lzc_q;
    if (in_valid && s1_ready) begin
      s1_sign_d = in_sign;
      s1_e_d    = in_e;
      s1_m_d    = in_m;
      s1_tag_d  = in_tag;
      s1_lzc_d  = lzc_w;
      if (in_m == '0)        s1_cls_d = ZERO;
      else if (in_m[MAN_W-1]) s1_cls_d = CARRY;
      else                   s1_cls_d = NORM;
    end
  end

  assign in_ready = s1_ready;

  // Stage 2: exponent compares are one bit wider so they never wrap
  assign e_inc = {1'b0, s1_e_q} + (EXP_W+1)'(1);
  assign lzc_x = (EXP_W+1)'(s1_lzc_q);

  always_comb begin
    out_sign_d  = out_sign_q;
    out_e_d     = out_e_q;
    out_m_d     = out_m_q;
    out_guard_d = out_guard_q;
    out_tag_d   = out_tag_q;
    out_zero_d  = out_zero_q;
    out_ovf_d   = out_ovf_q;
    out_unf_d   = out_unf_q;
    if (vld_pipe_q[1] && s2_ready) begin
      out_sign_d  = s1_sign_q;
      out_tag_d   = s1_tag_q;
      out_guard_d = 1'b0;
      out_zero_d  = 1'b0;
      out_ovf_d   = 1'b0;
      out_unf_d   = 1'b0;
      unique case (s1_cls_q)
        ZERO: begin
          out_e_d    = '0;
          out_m_d    = '0;
          out_zero_d = 1'b1;
        end
        CARRY: begin
          if (e_inc >= (EXP_W+1)'(EXP_MAX(EXP_W))) begin
            out_e_d   = '1;
            out_m_d   = '0;
            out_ovf_d = 1'b1;
          end else begin
            out_e_d     = s1_e_q + EXP_W'(1);
            out_m_d     = s1_m_q >> 1;
            out_guard_d = s1_m_q[0];
          end
        end
        default: begin
          if (lzc_x < {1'b0, s1_e_q}) begin
            out_m_d = s1_m_q << s1_lzc_q;
            out_e_d = s1_e_q - EXP_W'(s1_lzc_q);
          end else begin
            // Exponent runs out first: shift only down to the denormal
            // position (e=1 scale), or not at all if already at e=0.
            out_m_d   = (s1_e_q == '0) ? s1_m_q : (s1_m_q << (s1_e_q - EXP_W'(1)));
            out_e_d   = '0;
            out_unf_d = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_pipe_q  <= '0;
      s1_sign_q   <= 1'b0;
      s1_e_q      <= '0;
      s1_m_q      <= '0;
      s1_tag_q    <= '0;
      s1_cls_q    <= ZERO;
      s1_lzc_q    <= '0;
      out_sign_q  <= 1'b0;
      out_e_q     <= '0;
      out_m_q     <= '0;
      out_guard_q <= 1'b0;
      out_tag_q   <= '0;
      out_zero_q  <= 1'b0;
      out_ovf_q   <= 1'b0;
      out_unf_q   <= 1'b0;
    end else begin
      vld_pipe_q  <= vld_pipe_d;
      s1_sign_q   <= s1_sign_d;
      s1_e_q      <= s1_e_d;
      s1_m_q      <= s1_m_d;
      s1_tag_q    <= s1_tag_d;
      s1_cls_q    <= s1_cls_d;
      s1_lzc_q    <= s1_lzc_d;
      out_sign_q  <= out_sign_d;
      out_e_q     <= out_e_d;
      out_m_q     <= out_m_d;
      out_guard_q <= out_guard_d;
      out_tag_q   <= out_tag_d;
      out_zero_q  <= out_zero_d;
      out_ovf_q   <= out_ovf_d;
      out_unf_q   <= out_unf_d;
    end
  end

  assign out_valid = vld_pipe_q[2];
  assign out_sign  = out_sign_q;
  assign out_e     = out_e_q;
  assign out_m     = out_m_q;
  assign out_guard = out_guard_q;
  assign out_tag   = out_tag_q;
  assign out_zero  = out_zero_q;
  assign out_ovf   = out_ovf_q;
  assign out_unf   = out_unf_q;

endmodule

// File: tb/tb_fp_add_normaliser_pipe.sv
// Directed bench for fp_add_normaliser_pipe: reset state, each result
// class with its boundaries, backpressure streaming, and mid-stream reset.
module tb_fp_add_normaliser_pipe;

  localparam int EXP_W = 8;
  localparam int MAN_W = 25;
  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid, in_ready, in_sign;
  logic [EXP_W-1:0] in_e;
  logic [MAN_W-1:0] in_m;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid, out_ready, out_sign;
  logic [EXP_W-1:0] out_e;
  logic [MAN_W-1:0] out_m;
  logic             out_guard;
  logic [TAG_W-1:0] out_tag;
  logic             out_zero, out_ovf, out_unf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fp_add_normaliser_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_sign(in_sign),
    .in_e(in_e), .in_m(in_m), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_sign(out_sign),
    .out_e(out_e), .out_m(out_m), .out_guard(out_guard), .out_tag(out_tag),
    .out_zero(out_zero), .out_ovf(out_ovf), .out_unf(out_unf)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // xf = {guard, zero, ovf, unf}
  task automatic run_one(input string nm, input logic sg, input logic [EXP_W-1:0] e,
                         input logic [MAN_W-1:0] m, input logic [TAG_W-1:0] tg,
                         input logic [EXP_W-1:0] xe, input logic [MAN_W-1:0] xm,
                         input logic [3:0] xf);
    @(negedge clk);
    in_valid = 1'b1; in_sign = sg; in_e = e; in_m = m; in_tag = tg;
    #1 chk({nm, " in_ready"}, 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk({nm, " valid@1"}, 64'(out_valid), 64'd0);
    @(negedge clk);
    chk({nm, " valid@2"}, 64'(out_valid), 64'd1);
    chk({nm, " out_e"}, 64'(out_e), 64'(xe));
    chk({nm, " out_m"}, 64'(out_m), 64'(xm));
    chk({nm, " flags"}, 64'({out_guard, out_zero, out_ovf, out_unf}), 64'(xf));
    chk({nm, " sign/tag"}, 64'({out_sign, out_tag}), 64'({sg, tg}));
  endtask

  function automatic logic [63:0] outs();
    return 64'({out_tag, out_e, out_m, out_guard, out_zero, out_ovf, out_unf, out_sign, out_valid});
  endfunction

  initial begin
    int sent, nrecv, stall_acc, stale;
    logic [TAG_W-1:0] exp_tag;
    logic have_snap;
    logic [63:0] snap;

    reset = 1'b1; in_valid = 1'b0; in_sign = 1'b0; in_e = '0; in_m = '0; in_tag = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset outputs", outs(), 64'd0);
    reset = 1'b0;
    #1 chk("in_ready after reset", 64'(in_ready), 64'd1);

    run_one("left",      1'b0, 8'd130, 25'h0000008, 4'h1, 8'd110, 25'h0800000, 4'b0000);
    run_one("carry",     1'b0, 8'd127, 25'h1800001, 4'h2, 8'd128, 25'h0C00000, 4'b1000);
    run_one("carry g0",  1'b1, 8'd1,   25'h1000002, 4'h3, 8'd2,   25'h0800001, 4'b0000);
    run_one("overflow",  1'b0, 8'd254, 25'h1000000, 4'h4, 8'd255, 25'h0000000, 4'b0010);
    run_one("zero",      1'b1, 8'd77,  25'h0000000, 4'h5, 8'd0,   25'h0000000, 4'b0100);
    run_one("underflow", 1'b0, 8'd5,   25'h0000100, 4'h6, 8'd0,   25'h0001000, 4'b0001);
    run_one("unf e0",    1'b0, 8'd0,   25'h0000100, 4'h7, 8'd0,   25'h0000100, 4'b0001);
    run_one("lzc=e",     1'b0, 8'd20,  25'h0000008, 4'h8, 8'd0,   25'h0400000, 4'b0001);
    run_one("lzc max",   1'b1, 8'd200, 25'h0000001, 4'h9, 8'd177, 25'h0800000, 4'b0000);
    run_one("no shift",  1'b0, 8'd1,   25'h0800000, 4'hA, 8'd1,   25'h0800000, 4'b0000);

    // Backpressure: ops 1,2 then a 2-cycle gap, out_ready low in cycles 4..6
    sent = 0; nrecv = 0; stall_acc = 0; exp_tag = 4'd1; have_snap = 1'b0; snap = '0;
    for (int cyc = 0; cyc < 40 && nrecv < 6; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 4 && cyc <= 6);
      in_valid  = (sent < 6) && !(cyc == 2 || cyc == 3);
      in_tag = TAG_W'(sent + 1); in_e = 8'd130; in_m = 25'h0000008; in_sign = 1'b0;
      #1;
      if (have_snap) chk("bp stable", outs(), snap);
      have_snap = out_valid && !out_ready;
      snap = outs();
      if (cyc == 6) chk("bp in_ready drop", 64'(in_ready), 64'd0);
      if (out_valid && out_ready) begin
        chk("bp tag order", 64'(out_tag), 64'(exp_tag));
        exp_tag++;
        nrecv++;
      end
      if (in_valid && in_ready) begin
        sent++;
        if (cyc >= 4 && cyc <= 6) stall_acc++;
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("bp accepts in stall", 64'(stall_acc), 64'd2);
    chk("bp received", 64'(nrecv), 64'd6);

    // Reset with two ops in flight
    @(negedge clk); in_valid = 1'b1; in_tag = 4'hB; in_e = 8'd130; in_m = 25'h0000008;
    @(negedge clk); in_tag = 4'hC;
    @(negedge clk); in_valid = 1'b0; reset = 1'b1;
    #1 chk("reset flush outputs", outs(), 64'd0);
    @(negedge clk); reset = 1'b0;
    #1 chk("in_ready after flush", 64'(in_ready), 64'd1);
    stale = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    chk("no stale results", 64'(stale), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
